// File: rtl/matmul_pkg.sv
// Shared types and helpers for the sequential matrix multiplier:
// FSM state encoding, result-width rule and flat-bus element offsets.
package matmul_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Full-precision width for a sum of n products of dw-bit operands.
  function automatic int res_width(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

  function automatic int elem_a(input int i, input int j, input int n, input int dw);
    return (i * n + j) * dw;
  endfunction

  function automatic int elem_r(input int i, input int j, input int n, input int rw);
    return (i * n + j) * rw;
  endfunction

endpackage

// File: rtl/matrix_mult_seq_mac.sv
// Combinational multiply-accumulate step: signed/unsigned product,
// extended to RW bits, added to either the row/column base or the running sum.
module mac_unit #(
  parameter int DW = 8,
  parameter int RW = 18
) (
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  logic          i_signed,
  input  logic          i_first,
  input  logic [RW-1:0] i_base,
  input  logic [RW-1:0] i_acc,
  output logic [RW-1:0] o_sum
);
  logic signed [2*DW-1:0] w_prod_s;
  logic        [2*DW-1:0] w_prod_u;
  logic        [RW-1:0]   w_prod_ext;

  assign w_prod_s = $signed(i_a) * $signed(i_b);
  assign w_prod_u = i_a * i_b;

  always_comb begin
    w_prod_ext = {{(RW-2*DW){1'b0}}, w_prod_u};
    if (i_signed) begin
      w_prod_ext = {{(RW-2*DW){w_prod_s[2*DW-1]}}, w_prod_s};
    end
  end

  // The sum wraps modulo 2^RW, which only matters in accumulate mode.
  assign o_sum = (i_first ? i_base : i_acc) + w_prod_ext;

endmodule

// File: rtl/matrix_mult_seq.sv
// Sequential N x N matrix multiplier built around one shared MAC; operands and
// modes are captured on start, Result updates element by element and holds after done.
module matrix_mult_seq
  import matmul_pkg::*;
#(
  parameter int N  = 3,
  parameter int DW = 8,
  parameter int RW = res_width(DW, N)
) (
  input  logic              Clock,
  input  logic              reset,
  input  logic              start,
  input  logic              signed_mode,
  input  logic              acc_mode,
  input  logic [N*N*DW-1:0] A,
  input  logic [N*N*DW-1:0] B,
  output logic [N*N*RW-1:0] Result,
  output logic              busy,
  output logic              done
);
  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [CW-1:0]     r_i, r_j, r_k;
  logic [RW-1:0]     r_acc;
  logic [N*N*RW-1:0] r_result;
  logic [N*N*DW-1:0] r_a, r_b;
  logic              r_signed, r_acc_mode;
  logic              w_last;
  logic [DW-1:0]     w_a_elem, w_b_elem;
  logic [RW-1:0]     w_base, w_sum;

  assign w_last   = (r_i == LAST) && (r_j == LAST) && (r_k == LAST);
  assign w_a_elem = r_a[elem_a(int'(r_i), int'(r_k), N, DW) +: DW];
  assign w_b_elem = r_b[elem_a(int'(r_k), int'(r_j), N, DW) +: DW];
  assign w_base   = r_acc_mode ? r_result[elem_r(int'(r_i), int'(r_j), N, RW) +: RW] : '0;
  assign Result   = r_result;

  mac_unit #(.DW(DW), .RW(RW)) u_mac (
    .i_a      (w_a_elem),
    .i_b      (w_b_elem),
    .i_signed (r_signed),
    .i_first  (r_k == '0),
    .i_base   (w_base),
    .i_acc    (r_acc),
    .o_sum    (w_sum)
  );

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: if (start) w_state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      r_i        <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_acc      <= '0;
      r_result   <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_signed   <= 1'b0;
      r_acc_mode <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a        <= A;
            r_b        <= B;
            r_signed   <= signed_mode;
            r_acc_mode <= acc_mode;
            r_i        <= '0;
            r_j        <= '0;
            r_k        <= '0;
          end
        end
        RUN: begin
          r_acc <= w_sum;
          // k is innermost; an element is committed when its dot product completes.
          if (r_k == LAST) begin
            r_result[elem_r(int'(r_i), int'(r_j), N, RW) +: RW] <= w_sum;
            r_k <= '0;
            if (r_j == LAST) begin
              r_j <= '0;
              r_i <= (r_i == LAST) ? '0 : r_i + 1'b1;
            end else begin
              r_j <= r_j + 1'b1;
            end
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/matrix_mult_seq.md
Name: matrix_mult_seq

Overview:
- Parametrised successor to the fixed 3x3 8-bit Calculator.
- Multiplies two square N x N matrices of DW-bit elements, packed row-major on flat buses, using one time-shared multiply-accumulate (MAC) unit.
- Adds a start/busy/done handshake, a signed/unsigned mode and an accumulate mode (C <= C + A*B).
- Sits in the datapath between the operand registers and the result consumer. Result is held stable until the next accepted start.

Parameters:
- N, 3, matrix dimension (N >= 2).
- DW, 8, input element width in bits.
- RW, 2*DW+$clog2(N), result element width in bits; full precision for N products.

Ports:
- Clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  request; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement operands; captured on start.
- acc_mode  in  1  1 = add product to the previous Result; captured on start.
- A  in  N*N*DW  element (i,j) at [(i*N+j)*DW +: DW].
- B  in  N*N*DW  same packing as A.
- Result  out  N*N*RW  element (i,j) at [(i*N+j)*RW +: RW].
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when Result is final.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, i=j=k=0, accumulator=0, Result=0, busy=0, done=0. Reset mid-RUN aborts with the same values; no partial result survives.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge T0:
  - Capture A, B, signed_mode and acc_mode into internal registers; later input changes have no effect.
  - i=j=k=0; go to RUN; busy=1 from T0.
- RUN, one MAC per edge, k innermost, then j, then i:
  - prod = A[i][k]*B[k][j]. Signed or unsigned per the captured mode; sign-extend to RW when signed.
  - sum = (k==0 ? base : acc) + prod, modulo 2^RW.
  - base = Result[i][j] when acc_mode=1, otherwise 0.
  - acc <= sum each edge.
  - When k==N-1: Result[i][j] <= sum; k wraps to 0 and j increments. When j wraps, i increments.
  - Result elements update progressively during RUN. Consumers must wait for done.
- After the final MAC (i=j=k=N-1, edge T0+N^3): state=DONE, busy=0, done=1 for exactly one cycle.
- DONE -> IDLE unconditionally on the next edge. start asserted during DONE is ignored.
- start while busy is ignored; there is no queueing.
- Latency: done is high in the cycle after edge T0+N^3, i.e. 27 MAC cycles for N=3.
- Back-to-back operation: the earliest next start is sampled at edge T0+N^3+2.
- Result holds its last value in IDLE and DONE.
- Overflow: none is possible in non-accumulate mode. In acc_mode, wrap modulo 2^RW; no saturation.

Decomposition:
- Package matmul_pkg:
  - state enum {IDLE, RUN, DONE};
  - a localparam helper for RW;
  - index-to-offset functions elem_a(i,j) and elem_r(i,j).
- Sub-module mac_unit (DW, RW):
  - combinational product with signed/unsigned select;
  - sign/zero extension to RW;
  - addition with the base/acc select.
- The top level holds the FSM, counters, captured operands and the Result register file.

Test Plan:
- N=3, DW=8, unsigned. A = {9,8,7,6,5,4,3,2,1}, B = {1,9,8,7,6,5,4,3,2} (element 0 is the LSB slice). Pulse start -> done exactly 28 edges after the start edge. Result C[0][0]=36, C[0][1]=42, C[0][2]=21, C[1][1]=96, C[2][2]=93.
- Same operands, second run with acc_mode=1 -> C[0][0]=72, C[2][2]=186. Then acc_mode=0 -> C[0][0]=36 again.
- Sign handling, all elements of A and B = 8'hFF:
  - signed_mode=1 -> every C = 3;
  - signed_mode=0 -> every C = 195075 (18-bit, no wrap).
- Reset mid-run: drive reset=0 for one cycle at MAC cycle 10 -> busy=0, done=0 and Result=0 immediately (asynchronous). A fresh start then gives the case-1 values.
- Ignored inputs and isolation:
  - start held high through RUN -> exactly one done pulse per accepted start;
  - changing A/B during RUN does not alter the result;
  - start during DONE is ignored.
- N=2, DW=4 instance: A = {4,3,2,1}, B = {8,7,6,5} -> C = {50,43,22,19} (C[0][0]=19, C[1][1]=50). done is asserted 9 edges after the start edge.
